// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-8 Booth sequential multiplier.
package booth_pkg;

  typedef enum logic [1:0] {IDLE, PRECOMP, ITER, DONE} state_e;

  typedef struct packed {
    logic       neg;
    logic [2:0] mag;
  } digit_t;

  function automatic int ndig(input int bw);
    return (bw + 2) / 3;
  endfunction

  // Window {b3,b2,b1,b0} -> -4*b3 + 2*b2 + b1 + b0; magnitude 0 is never negative.
  function automatic digit_t booth_decode(input logic [3:0] w);
    digit_t     d;
    logic [2:0] s;
    s = {1'b0, w[2], 1'b0} + {2'b00, w[1]} + {2'b00, w[0]};
    if (!w[3]) begin
      d.neg = 1'b0;
      d.mag = s;
    end else begin
      d.mag = 3'd4 - s;
      d.neg = (s != 3'd4);
    end
    return d;
  endfunction

endpackage

// File: rtl/booth_r8_digit_sel.sv
// Combinational partial-product select for one radix-8 Booth digit.
module booth_r8_digit_sel
  import booth_pkg::*;
#(
  parameter int A_W = 16,
  parameter int P_W = 32
) (
  input  logic        [3:0]     win_i,
  input  logic signed [A_W-1:0] a_i,
  input  logic signed [A_W:0]   a2_i,
  input  logic signed [A_W+1:0] a3_i,
  input  logic signed [A_W+1:0] a4_i,
  output logic signed [P_W-1:0] pp_o
);

  digit_t                d;
  logic signed [A_W+1:0] mult;
  logic signed [P_W-1:0] mult_x;

  always_comb begin
    d    = booth_decode(win_i);
    mult = '0;
    case (d.mag)
      3'd1:    mult = (A_W+2)'(a_i);
      3'd2:    mult = (A_W+2)'(a2_i);
      3'd3:    mult = a3_i;
      3'd4:    mult = a4_i;
      default: mult = '0;
    endcase
    mult_x = P_W'(mult);
    pp_o   = d.neg ? -mult_x : mult_x;
  end

endmodule

// File: rtl/booth_r8_seq_mult.sv
// Radix-8 Booth sequential signed multiplier, one digit per cycle, MSB-first.
// Define BOOTH_MULT_SAT_EN to saturate the product into OUT_W and flag ovf_o.
module booth_r8_seq_mult
  import booth_pkg::*;
#(
  parameter int A_W   = 16,
  parameter int B_W   = 16,
  parameter int OUT_W = A_W + B_W
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic signed [A_W-1:0]   a_i,
  input  logic signed [B_W-1:0]   b_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic signed [OUT_W-1:0] prod_o,
  output logic                    ovf_o
);

  localparam int P_W   = A_W + B_W;
  localparam int ND    = ndig(B_W);
  localparam int BX_W  = 3 * ND + 1;
  localparam int IDX_W = $clog2(ND + 1);

  state_e                state_q;
  logic signed [A_W-1:0] a_q;
  logic signed [B_W-1:0] b_q;
  logic signed [A_W+1:0] a3_q;
  logic signed [P_W-1:0] acc_q, acc_d, pp;
  logic [IDX_W-1:0]      idx_q;

  logic signed [A_W:0]    a2;
  logic signed [A_W+1:0]  a4;
  logic signed [BX_W-2:0] b_sx;
  logic [BX_W-1:0]        bx;
  logic [3:0]             win;

  assign a2   = {a_q, 1'b0};
  assign a4   = {a_q, 2'b00};
  assign b_sx = (BX_W-1)'(b_q);
  assign bx   = {b_sx, 1'b0};
  assign win  = bx[3*idx_q +: 4];

  booth_r8_digit_sel #(.A_W(A_W), .P_W(P_W)) u_sel (
    .win_i (win),
    .a_i   (a_q),
    .a2_i  (a2),
    .a3_i  (a3_q),
    .a4_i  (a4),
    .pp_o  (pp)
  );

  assign acc_d = (acc_q <<< 3) + pp;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      a3_q    <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid_i) begin
          a_q     <= a_i;
          b_q     <= b_i;
          acc_q   <= '0;
          state_q <= PRECOMP;
        end
        PRECOMP: begin
          a3_q    <= (A_W+2)'(a_q) + (A_W+2)'(a2);
          idx_q   <= IDX_W'(ND - 1);
          state_q <= ITER;
        end
        ITER: begin
          acc_q <= acc_d;
          idx_q <= idx_q - 1'b1;
          if (idx_q == '0) state_q <= DONE;
        end
        DONE: if (out_ready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  logic signed [OUT_W-1:0] res;
  logic                    ovf;

`ifdef BOOTH_MULT_SAT_EN
  if (OUT_W < P_W) begin : g_sat
    // Product fits iff every bit from OUT_W-1 upward equals the sign.
    logic [P_W-OUT_W:0] hi;
    assign hi  = acc_q[P_W-1:OUT_W-1];
    assign ovf = ~((&hi) | ~(|hi));
    always_comb begin
      if (!ovf)            res = acc_q[OUT_W-1:0];
      else if (acc_q[P_W-1]) res = {1'b1, {(OUT_W-1){1'b0}}};
      else                 res = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end else begin : g_full
    assign res = acc_q[OUT_W-1:0];
    assign ovf = 1'b0;
  end
`else
  assign res = acc_q[OUT_W-1:0];
  assign ovf = 1'b0;
`endif

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign prod_o      = out_valid_o ? res : '0;
  assign ovf_o       = out_valid_o & ovf;

endmodule

// File: tb/tb_booth_r8_seq_mult.sv
// Self-checking bench: directed 8x8 cases (full and 8-bit output) plus random 13x7 pairs.
module tb_booth_r8_seq_mult;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              v8, or8, ir8, ov8, ovf8, ir8n, ov8n, ovf8n;
  logic signed [7:0] a8, b8;
  logic [15:0]       p8;
  logic [7:0]        p8n;

  logic              v13, or13, ir13, ov13, ovf13;
  logic [12:0]       a13;
  logic [6:0]        b13;
  logic [19:0]       p13;

  int pass_n = 0, tot_n = 0, fail_n = 0;

  booth_r8_seq_mult #(.A_W(8), .B_W(8)) u8 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v8), .in_ready_o(ir8),
    .a_i(a8), .b_i(b8), .out_valid_o(ov8), .out_ready_i(or8),
    .prod_o(p8), .ovf_o(ovf8));

  booth_r8_seq_mult #(.A_W(8), .B_W(8), .OUT_W(8)) u8n (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v8), .in_ready_o(ir8n),
    .a_i(a8), .b_i(b8), .out_valid_o(ov8n), .out_ready_i(or8),
    .prod_o(p8n), .ovf_o(ovf8n));

  booth_r8_seq_mult #(.A_W(13), .B_W(7)) u13 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v13), .in_ready_o(ir13),
    .a_i(a13), .b_i(b13), .out_valid_o(ov13), .out_ready_i(or13),
    .prod_o(p13), .ovf_o(ovf13));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tot_n++;
    assert (obs === exp) pass_n++;
    else begin
      fail_n++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer product, then saturate or truncate into ow bits.
  function automatic logic [63:0] refm(input longint a, input longint b, input int ow,
                                       output logic ovf);
    longint p, mx, mn;
    p   = a * b;
    mx  = (longint'(1) <<< (ow - 1)) - 1;
    mn  = -mx - 1;
    ovf = 1'b0;
`ifdef BOOTH_MULT_SAT_EN
    if (p > mx) begin p = mx; ovf = 1'b1; end
    else if (p < mn) begin p = mn; ovf = 1'b1; end
`endif
    return 64'(p) & ((64'd1 << ow) - 64'd1);
  endfunction

  task automatic op8(input int a, input int b, input int hold);
    logic [63:0] e;
    logic        eo;
    logic [15:0] held;
    int          cyc;
    a8 = 8'(a); b8 = 8'(b); v8 = 1'b1; or8 = (hold == 0);
    @(posedge clk); #1 v8 = 1'b0;
    cyc = 0;
    while (!ov8 && cyc < 20) begin @(posedge clk); #1 cyc++; end
    chk("lat8", 64'(cyc), 64'd4);
    e = refm(a, b, 16, eo);
    chk("prod16", 64'(p8), e);
    chk("ovf16", 64'(ovf8), 64'(eo));
    e = refm(a, b, 8, eo);
    chk("prod8", 64'(p8n), e);
    chk("ovf8", 64'(ovf8n), 64'(eo));
    held = p8;
    for (int i = 0; i < hold; i++) begin
      v8 = 1'b1; a8 = ~a8;
      @(posedge clk); #1;
      chk("hold_vld", 64'(ov8), 64'd1);
      chk("hold_prod", 64'(p8), 64'(held));
      chk("hold_rdy", 64'(ir8), 64'd0);
    end
    v8 = 1'b0; or8 = 1'b1;
    @(posedge clk); #1;
    chk("idle_rdy", 64'(ir8), 64'd1);
    chk("idle_vld", 64'(ov8), 64'd0);
  endtask

  task automatic op13(input int a, input int b);
    logic [63:0] e;
    logic        eo;
    int          cyc;
    a13 = 13'(a); b13 = 7'(b); v13 = 1'b1;
    @(posedge clk); #1 v13 = 1'b0;
    cyc = 0;
    while (!ov13 && cyc < 20) begin @(posedge clk); #1 cyc++; end
    chk("lat13", 64'(cyc), 64'd4);
    e = refm(a, b, 20, eo);
    chk("prod13", 64'(p13), e);
    chk("ovf13", 64'(ovf13), 64'(eo));
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; v8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0;
    v13 = 1'b0; or13 = 1'b1; a13 = '0; b13 = '0;
    #1;
    chk("rst_rdy", 64'(ir8), 64'd1);
    chk("rst_vld", 64'(ov8), 64'd0);
    chk("rst_prod", 64'(p8), 64'd0);
    chk("rst_ovf", 64'(ovf8n), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    op8(-128, -128, 0);
    op8(127, -1, 0);
    op8(0, -77, 0);
    op8(-3, 3, 0);
    op8(100, 100, 5);

    // Reset during the second ITER cycle must abort with no result.
    a8 = -8'sd100; b8 = 8'sd77; v8 = 1'b1;
    @(posedge clk); #1 v8 = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("mid_rdy", 64'(ir8), 64'd1);
    chk("mid_vld", 64'(ov8), 64'd0);
    chk("mid_prod", 64'(p8), 64'd0);
    chk("mid_ovf", 64'(ovf8n), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_vld", 64'(ov8), 64'd0);
      chk("post_rdy", 64'(ir8), 64'd1);
    end
    op8(5, 6, 0);

    op13(-4096, -64);
    op13(4095, 63);
    op13(-4096, 63);
    op13(0, -64);
    for (int i = 0; i < 10000; i++)
      op13(int'($urandom_range(0, 8191)) - 4096, int'($urandom_range(0, 127)) - 64);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
